io_out_capture: RTL and testbench
=================================

Name: io_out_capture

Overview:
- Sits directly downstream of the bit16 core and consumes its io_out bus.
- Detects each new value the core drives on io_out and tags it with a free-running cycle timestamp.
- Buffers tagged samples in a small FIFO and drains them to a host/monitor over a valid/ready handshake.
- Lets test and debug logic collect the core's output trace without stalling the core.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- TS_W, 16, timestamp counter width in bits.
- DROP_W, 8, width of the saturating dropped-sample counter.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-low reset; 0 on a rising clk edge resets the block.
- io_out  in  16  output bus from the bit16 core.
- cap_en  in  1  capture enable; 0 suppresses change detection only.
- clr_ovf  in  1  one-cycle pulse; clears ovf and drop_cnt.
- m_valid  out  1  FIFO head is valid.
- m_ready  in  1  consumer accepts the head this cycle.
- m_data  out  16  captured io_out value at the FIFO head.
- m_ts  out  TS_W  timestamp of the FIFO head.
- level  out  log2(DEPTH)+1  current FIFO occupancy.
- ovf  out  1  sticky flag: at least one sample was dropped.
- drop_cnt  out  DROP_W  number of dropped samples, saturating.

Behaviour:
- Reset (rst=0 at an edge):
  - FIFO empty; m_valid=0, m_data=0, m_ts=0, level=0.
  - ovf=0, drop_cnt=0.
  - Timestamp counter ts=0; previous-value register prev=0.
  - Reset mid-operation discards all buffered entries; nothing is drained afterwards.
- Timestamp:
  - ts increments by 1 every cycle out of reset.
  - Wraps from 2^TS_W-1 to 0 with no flag.
- Change detection:
  - A capture event occurs in cycle t when cap_en=1 and io_out != prev.
  - prev <= io_out every cycle, regardless of cap_en.
  - Consequence: a change that happens while cap_en=0 is never captured later.
  - The captured entry is {io_out, ts}, using the values sampled in cycle t.
- Latency:
  - An entry pushed into an empty FIFO at edge t+1 makes m_valid=1 in the cycle after that edge.
  - Total: one cycle from the io_out change to m_valid.
- Handshake:
  - A pop occurs when m_valid=1 and m_ready=1.
  - m_data and m_ts are stable while m_valid=1 and m_ready=0.
  - m_ready while empty has no effect.
- Push/pop interaction (level is updated in the same edge):
  - Push and pop in the same cycle when not full: both happen; level is unchanged.
  - Capture event when full with no pop: the new sample is dropped; ovf<=1; drop_cnt increments, saturating at 2^DROP_W-1.
  - Capture event when full with a simultaneous pop: both happen; no drop.
- clr_ovf:
  - Clears ovf and drop_cnt.
  - If a drop happens in the same cycle, the drop wins: ovf=1, drop_cnt=1.
- Storage:
  - Circular buffer with read/write pointers of log2(DEPTH) bits, wrapping modulo DEPTH.
  - Full when level==DEPTH; empty when level==0.
  - m_data/m_ts are driven combinationally from the head entry; they read 0 when empty.
- Structure: no state machine beyond the FIFO control; all outputs are registered except m_data/m_ts.

Decomposition:
- Shared package bit16_pkg:
  - IO_W=16 (io_out width).
  - Typedef cap_entry_t = {data[15:0], ts[TS_W-1:0]}.
- Natural sub-module sync_fifo: parameterised synchronous FIFO with push/pop/full/empty/level.
- io_out_capture holds the change detector, timestamp counter, overflow/drop logic and the sync_fifo instance.

Test Plan:
1. Reset, then hold io_out=0 with cap_en=1 for 20 cycles -> m_valid stays 0, level=0, ts reaches 20.
2. At ts=5 drive io_out=16'h1234 with m_ready=0 -> next cycle m_valid=1, m_data=1234, m_ts=5, level=1; both stay stable until m_ready=1, then level=0.
3. m_ready=0; change io_out every cycle through 10 distinct values -> level=8, ovf=1, drop_cnt=2; draining yields the first 8 values in order with increasing m_ts.
4. FIFO full, m_ready=1, and a new io_out value in the same cycle -> level stays 8, no drop (drop_cnt unchanged), new value appears last in the drain order.
5. cap_en=0 while io_out goes 0→16'hBEEF, then cap_en=1 with io_out held at BEEF -> no entry pushed; a later change to 16'hBEF0 is captured.
6. Three entries buffered, then pulse rst=0 for one edge -> level=0, m_valid=0, ovf=0, ts=0; clr_ovf applied in the same cycle as a drop -> ovf=1, drop_cnt=1.

Source files
------------

// File: rtl/bit16_pkg.sv
// Shared definitions for blocks that sit on the bit16 core's io_out bus.
package bit16_pkg;

  localparam int IO_W     = 16;
  localparam int CAP_TS_W = 16;

  typedef struct packed {
    logic [IO_W-1:0]     data;
    logic [CAP_TS_W-1:0] ts;
  } cap_entry_t;

endpackage

// File: rtl/io_out_capture_fifo.sv
// Synchronous circular-buffer FIFO with registered level/full/empty and a head
// output that reads zero while empty.
module sync_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_q, rd_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [LW-1:0] level_q, level_d;
  logic          full_q, empty_q;
  logic          do_push, do_pop;

  // A push into a full buffer is only legal when the head leaves in the same edge.
  assign do_pop  = pop && !empty_q;
  assign do_push = push && (!full_q || do_pop);

  always_comb begin
    rd_d    = rd_q;
    wr_d    = wr_q;
    level_d = level_q;
    if (do_pop) begin
      rd_d = rd_q + AW'(1);
    end
    if (do_push) begin
      wr_d = wr_q + AW'(1);
    end
    if (do_push && !do_pop) begin
      level_d = level_q + LW'(1);
    end else if (do_pop && !do_push) begin
      level_d = level_q - LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_q    <= '0;
      wr_q    <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      level_q <= level_d;
      full_q  <= (level_d == LW'(DEPTH));
      empty_q <= (level_d == '0);
    end
  end

  // Storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_q] <= wdata;
    end
  end

  assign rdata = empty_q ? '0 : mem[rd_q];
  assign full  = full_q;
  assign empty = empty_q;
  assign level = level_q;

endmodule

// File: rtl/io_out_capture.sv
// Captures each new io_out value from the bit16 core with a cycle timestamp and
// streams the tagged samples out of a small FIFO over valid/ready.
module io_out_capture
  import bit16_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int TS_W   = 16,
  parameter int DROP_W = 8,
  localparam int LW    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IO_W-1:0]   io_out,
  input  logic              cap_en,
  input  logic              clr_ovf,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [IO_W-1:0]   m_data,
  output logic [TS_W-1:0]   m_ts,
  output logic [LW-1:0]     level,
  output logic              ovf,
  output logic [DROP_W-1:0] drop_cnt
);

  typedef struct packed {
    logic [IO_W-1:0] data;
    logic [TS_W-1:0] ts;
  } entry_t;

  logic [TS_W-1:0]   ts_q, ts_d;
  logic [IO_W-1:0]   prev_q, prev_d;
  logic              ovf_q, ovf_d;
  logic [DROP_W-1:0] drop_q, drop_d;

  logic   cap, pop, drop, push;
  logic   fifo_full, fifo_empty;
  entry_t wr_entry, rd_entry;

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (v == '1) ? v : v + DROP_W'(1);
  endfunction

  // Change detection compares against last cycle's bus even while capture is disabled.
  assign cap  = cap_en && (io_out != prev_q);
  assign pop  = m_valid && m_ready;
  assign drop = cap && fifo_full && !pop;
  assign push = cap && !drop;

  assign wr_entry = '{data: io_out, ts: ts_q};

  always_comb begin
    ts_d   = ts_q + TS_W'(1);
    prev_d = io_out;
    ovf_d  = ovf_q;
    drop_d = drop_q;
    if (drop) begin
      ovf_d  = 1'b1;
      drop_d = clr_ovf ? DROP_W'(1) : sat_inc(drop_q);
    end else if (clr_ovf) begin
      ovf_d  = 1'b0;
      drop_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ts_q   <= '0;
      prev_q <= '0;
      ovf_q  <= 1'b0;
      drop_q <= '0;
    end else begin
      ts_q   <= ts_d;
      prev_q <= prev_d;
      ovf_q  <= ovf_d;
      drop_q <= drop_d;
    end
  end

  sync_fifo #(
    .W     (IO_W + TS_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (wr_entry),
    .rdata (rd_entry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  assign m_valid  = !fifo_empty;
  assign m_data   = rd_entry.data;
  assign m_ts     = rd_entry.ts;
  assign ovf      = ovf_q;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_io_out_capture.sv
// Randomized and directed bench for io_out_capture against a queue-based model.
module tb_io_out_capture;

  localparam int DEPTH  = 8;
  localparam int TS_W   = 16;
  localparam int DROP_W = 8;
  localparam int LW     = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [15:0]       io_out;
  logic              cap_en;
  logic              clr_ovf;
  logic              m_valid;
  logic              m_ready;
  logic [15:0]       m_data;
  logic [TS_W-1:0]   m_ts;
  logic [LW-1:0]     level;
  logic              ovf;
  logic [DROP_W-1:0] drop_cnt;

  int checks   = 0;
  int failures = 0;

  io_out_capture #(.DEPTH(DEPTH), .TS_W(TS_W), .DROP_W(DROP_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .io_out   (io_out),
    .cap_en   (cap_en),
    .clr_ovf  (clr_ovf),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_ts     (m_ts),
    .level    (level),
    .ovf      (ovf),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural reference: a queue of samples plus scalar flags.
  logic [15:0]       q_data[$];
  logic [TS_W-1:0]   q_ts[$];
  logic [TS_W-1:0]   mdl_ts   = '0;
  logic [15:0]       mdl_prev = '0;
  logic              mdl_ovf  = 1'b0;
  logic [DROP_W-1:0] mdl_drop = '0;
  bit                started  = 0;

  always @(posedge clk) begin
    bit was_full, popped, change;
    if (!rst) begin
      q_data.delete();
      q_ts.delete();
      mdl_ts   = '0;
      mdl_prev = '0;
      mdl_ovf  = 1'b0;
      mdl_drop = '0;
    end else begin
      was_full = (q_data.size() == DEPTH);
      popped   = (q_data.size() > 0) && m_ready;
      change   = cap_en && (io_out != mdl_prev);
      if (popped) begin
        void'(q_data.pop_front());
        void'(q_ts.pop_front());
      end
      if (change && was_full && !popped) begin
        mdl_ovf = 1'b1;
        if (clr_ovf) mdl_drop = 1;
        else if (mdl_drop != {DROP_W{1'b1}}) mdl_drop = mdl_drop + 1;
      end else begin
        if (change) begin
          q_data.push_back(io_out);
          q_ts.push_back(mdl_ts);
        end
        if (clr_ovf) begin
          mdl_ovf  = 1'b0;
          mdl_drop = '0;
        end
      end
      mdl_prev = io_out;
      mdl_ts   = mdl_ts + 1;
    end
    started = 1;
  end

  always @(negedge clk) begin
    if (started) begin
      check("m_valid", 32'(m_valid), 32'(q_data.size() != 0));
      check("level", 32'(level), 32'(q_data.size()));
      check("m_data", 32'(m_data), (q_data.size() != 0) ? 32'(q_data[0]) : 32'h0);
      check("m_ts", 32'(m_ts), (q_ts.size() != 0) ? 32'(q_ts[0]) : 32'h0);
      check("ovf", 32'(ovf), 32'(mdl_ovf));
      check("drop_cnt", 32'(drop_cnt), 32'(mdl_drop));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    io_out  = '0;
    cap_en  = 1'b1;
    clr_ovf = 1'b0;
    m_ready = 1'b0;
    rst     = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  initial begin
    rst     = 1'b0;
    io_out  = '0;
    cap_en  = 1'b1;
    clr_ovf = 1'b0;
    m_ready = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    check("rst_valid", 32'(m_valid), 32'h0);
    check("rst_level", 32'(level), 32'h0);
    check("rst_ovf", 32'(ovf), 32'h0);
    check("rst_drop", 32'(drop_cnt), 32'h0);

    // Idle bus: nothing captured, timestamp keeps running.
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle_valid", 32'(m_valid), 32'h0);
    end
    io_out = 16'h0001;
    tick();
    check("ts_after_20", 32'(m_ts), 32'd20);

    // Single capture at ts=5, held until accepted.
    do_reset();
    repeat (5) tick();
    io_out = 16'h1234;
    tick();
    check("t2_valid", 32'(m_valid), 32'h1);
    check("t2_data", 32'(m_data), 32'h1234);
    check("t2_ts", 32'(m_ts), 32'd5);
    check("t2_level", 32'(level), 32'd1);
    repeat (3) begin
      tick();
      check("t2_hold_data", 32'(m_data), 32'h1234);
      check("t2_hold_ts", 32'(m_ts), 32'd5);
    end
    m_ready = 1'b1;
    tick();
    check("t2_drained", 32'(level), 32'd0);
    m_ready = 1'b0;

    // Overflow: ten changes into eight slots.
    do_reset();
    for (int k = 0; k < 10; k++) begin
      io_out = 16'(k + 1);
      tick();
    end
    check("t3_level", 32'(level), 32'd8);
    check("t3_ovf", 32'(ovf), 32'h1);
    check("t3_drop", 32'(drop_cnt), 32'd2);
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("t3_order", 32'(m_data), 32'(i + 1));
      check("t3_ts", 32'(m_ts), 32'(i));
      tick();
    end
    check("t3_empty", 32'(level), 32'd0);

    // Push and pop together while full: no drop.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      io_out = 16'(16'h0101 + k);
      tick();
    end
    check("t4_full", 32'(level), 32'd8);
    io_out  = 16'h02AA;
    m_ready = 1'b1;
    tick();
    check("t4_level", 32'(level), 32'd8);
    check("t4_nodrop", 32'(drop_cnt), 32'd0);
    for (int i = 0; i < 8; i++) begin
      check("t4_order", 32'(m_data), (i < 7) ? 32'(16'h0102 + i) : 32'h02AA);
      tick();
    end

    // A change while disabled is lost for good.
    do_reset();
    cap_en = 1'b0;
    io_out = 16'hBEEF;
    tick();
    cap_en = 1'b1;
    repeat (3) tick();
    check("t5_none", 32'(level), 32'd0);
    io_out = 16'hBEF0;
    tick();
    check("t5_level", 32'(level), 32'd1);
    check("t5_data", 32'(m_data), 32'hBEF0);

    // Reset mid-operation, then clear colliding with a drop.
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      io_out = 16'(k);
      tick();
    end
    check("t6_three", 32'(level), 32'd3);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("t6_level", 32'(level), 32'd0);
    check("t6_valid", 32'(m_valid), 32'h0);
    tick();
    check("t6_ts0", 32'(m_ts), 32'd0);
    check("t6_data", 32'(m_data), 32'd3);
    for (int k = 0; k < 9; k++) begin
      io_out = 16'(16'h0010 + k);
      tick();
    end
    check("t6_drop2", 32'(drop_cnt), 32'd2);
    io_out  = 16'h0040;
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("t6_clr_ovf", 32'(ovf), 32'h1);
    check("t6_clr_drop", 32'(drop_cnt), 32'd1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("t6_cleared", 32'(drop_cnt), 32'd0);

    // Drop counter saturation.
    for (int k = 0; k < 300; k++) begin
      io_out = 16'(16'h0500 + k);
      tick();
    end
    check("sat_drop", 32'(drop_cnt), 32'd255);
    check("sat_ovf", 32'(ovf), 32'h1);

    // Randomized traffic.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      io_out  = 16'($urandom_range(0, 5));
      cap_en  = ($urandom_range(0, 9) != 0);
      m_ready = ($urandom_range(0, 2) == 0);
      clr_ovf = ($urandom_range(0, 40) == 0);
      rst     = ($urandom_range(0, 250) != 0);
      tick();
    end
    rst = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
